// File: rtl/lcd_status_pkg.sv
// Shared constants for the LCD status writer: main-FSM state codes, HD44780 commands,
// message geometry and the writer's own sequencing states.
package lcd_status_pkg;

  localparam int unsigned MSG_LEN = 16;

  // State codes as produced by the main control FSM
  localparam logic [3:0] ST_HOLA         = 4'd0;
  localparam logic [3:0] ST_MEASURE      = 4'd1;
  localparam logic [3:0] ST_FAULT_S1     = 4'd2;
  localparam logic [3:0] ST_FAULT_S2     = 4'd3;
  localparam logic [3:0] ST_FAULT_S3     = 4'd4;
  localparam logic [3:0] ST_OPEN_S1      = 4'd5;
  localparam logic [3:0] ST_OPEN_S2      = 4'd6;
  localparam logic [3:0] ST_OPEN_S3      = 4'd7;
  localparam logic [3:0] ST_CLOSE_S1     = 4'd8;
  localparam logic [3:0] ST_CLOSE_S2     = 4'd9;
  localparam logic [3:0] ST_CLOSE_S3     = 4'd10;
  localparam logic [3:0] ST_FAULT_DEF_S1 = 4'd11;
  localparam logic [3:0] ST_FAULT_DEF_S2 = 4'd12;
  localparam logic [3:0] ST_FAULT_DEF_S3 = 4'd13;

  localparam logic [7:0] CMD_FUNC_SET   = 8'h38;
  localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_LINE1      = 8'h80;
  localparam logic [7:0] CMD_LINE2      = 8'hC0;
  localparam logic [7:0] CHAR_SPACE     = 8'h20;

  typedef enum logic [2:0] {
    S_POWERUP,
    S_INIT,
    S_IDLE,
    S_ADDR1,
    S_LINE1,
    S_ADDR2,
    S_LINE2
  } lcd_state_e;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = CMD_FUNC_SET;
      2'd1:    cmd = CMD_DISP_ON;
      2'd2:    cmd = CMD_ENTRY_MODE;
      default: cmd = CMD_CLEAR;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_msg_rom.sv
// Line-1 message table: main-FSM state code plus character index to ASCII.
// Every message is left-justified and space-padded to MSG_LEN characters.
module lcd_msg_rom
  import lcd_status_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [3:0] idx_i,
  output logic [7:0] char_o
);

  logic [MSG_LEN*8-1:0] msg;

  always_comb begin
    msg = {MSG_LEN{CHAR_SPACE}};
    case (state_i)
      ST_HOLA:         msg = {"HOLA", {12{CHAR_SPACE}}};
      ST_MEASURE:      msg = {"MIDIENDO", {8{CHAR_SPACE}}};
      ST_FAULT_S1:     msg = {"FALLA S1", {8{CHAR_SPACE}}};
      ST_FAULT_S2:     msg = {"FALLA S2", {8{CHAR_SPACE}}};
      ST_FAULT_S3:     msg = {"FALLA S3", {8{CHAR_SPACE}}};
      ST_OPEN_S1:      msg = {"ABRIENDO S1", {5{CHAR_SPACE}}};
      ST_OPEN_S2:      msg = {"ABRIENDO S2", {5{CHAR_SPACE}}};
      ST_OPEN_S3:      msg = {"ABRIENDO S3", {5{CHAR_SPACE}}};
      ST_CLOSE_S1:     msg = {"CERRANDO S1", {5{CHAR_SPACE}}};
      ST_CLOSE_S2:     msg = {"CERRANDO S2", {5{CHAR_SPACE}}};
      ST_CLOSE_S3:     msg = {"CERRANDO S3", {5{CHAR_SPACE}}};
      ST_FAULT_DEF_S1: msg = {"FALLA DEF S1", {4{CHAR_SPACE}}};
      ST_FAULT_DEF_S2: msg = {"FALLA DEF S2", {4{CHAR_SPACE}}};
      ST_FAULT_DEF_S3: msg = {"FALLA DEF S3", {4{CHAR_SPACE}}};
      default:         msg = {"ESTADO ??", {7{CHAR_SPACE}}};
    endcase
  end

  // Character 0 sits in the top byte; ~idx_i is 15 - idx_i
  assign char_o = msg[{~idx_i, 3'b000} +: 8];

endmodule

// File: rtl/lcd_status_writer.sv
// HD44780 status display writer: power-up wait, init, then two-line refresh on input change.
// Define LCD_VALUE_FIELD_EN to show value_in as "VAL=0xHH" on line 2.
module lcd_status_writer
  import lcd_status_pkg::*;
#(
  parameter int unsigned TICK_CYCLES   = 50000,
  parameter int unsigned POWERUP_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state_in,
  input  logic [7:0] value_in,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       busy
);

  localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_CYCLES - 1);
  localparam int unsigned PwrW = (POWERUP_TICKS > 1) ? $clog2(POWERUP_TICKS) : 1;
  localparam logic [PwrW-1:0] PwrLast = PwrW'(POWERUP_TICKS - 1);
  localparam logic [3:0] InitCmds = 4'd4;
  localparam logic [3:0] InitLast = 4'd5;
  localparam logic [3:0] CharLast = 4'(MSG_LEN - 1);

  lcd_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PwrW-1:0] pwr_q, pwr_d;
  logic [3:0]      idx_q, idx_d;
  logic            phase_q, phase_d;
  logic            e_q, e_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic [3:0]      shown_state_q, shown_state_d;

  logic       tick;
  logic       sample_inputs;
  logic       refresh_req;
  logic [7:0] rom_char;
  logic [7:0] line2_char;
  logic [7:0] wr_byte;
  logic       wr_rs;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  assign tick  = (cnt_q == CntLast);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  assign shown_state_d = sample_inputs ? state_in : shown_state_q;

`ifdef LCD_VALUE_FIELD_EN
  logic [7:0] shown_value_q, shown_value_d;

  assign shown_value_d = sample_inputs ? value_in : shown_value_q;
  assign refresh_req   = (state_in != shown_state_q) || (value_in != shown_value_q);

  always_comb begin
    line2_char = CHAR_SPACE;
    case (idx_q)
      4'd0:    line2_char = 8'h56;  // V
      4'd1:    line2_char = 8'h41;  // A
      4'd2:    line2_char = 8'h4C;  // L
      4'd3:    line2_char = 8'h3D;  // =
      4'd4:    line2_char = 8'h30;  // 0
      4'd5:    line2_char = 8'h78;  // x
      4'd6:    line2_char = hex_ascii(shown_value_q[7:4]);
      4'd7:    line2_char = hex_ascii(shown_value_q[3:0]);
      default: line2_char = CHAR_SPACE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) shown_value_q <= 8'h00;
    else     shown_value_q <= shown_value_d;
  end
`else
  logic unused_value;

  assign unused_value = ^{value_in, hex_ascii(4'h0)};
  assign refresh_req  = (state_in != shown_state_q);
  assign line2_char   = CHAR_SPACE;
`endif

  lcd_msg_rom u_msg_rom (
    .state_i (shown_state_q),
    .idx_i   (idx_q),
    .char_o  (rom_char)
  );

  always_comb begin
    wr_byte = 8'h00;
    wr_rs   = 1'b0;
    case (state_q)
      S_INIT:  wr_byte = init_cmd(idx_q[1:0]);
      S_ADDR1: wr_byte = CMD_LINE1;
      S_LINE1: begin
        wr_byte = rom_char;
        wr_rs   = 1'b1;
      end
      S_ADDR2: wr_byte = CMD_LINE2;
      S_LINE2: begin
        wr_byte = line2_char;
        wr_rs   = 1'b1;
      end
      default: ;
    endcase
  end

  // Each byte spans two ticks: phase 0 raises E with data, phase 1 drops E and advances.
  always_comb begin
    state_d       = state_q;
    pwr_d         = pwr_q;
    idx_d         = idx_q;
    phase_d       = phase_q;
    e_d           = e_q;
    rs_d          = rs_q;
    data_d        = data_q;
    sample_inputs = 1'b0;
    if (tick) begin
      case (state_q)
        S_POWERUP: begin
          if (pwr_q == PwrLast) state_d = S_INIT;
          else                  pwr_d   = pwr_q + 1'b1;
        end
        S_IDLE: begin
          if (refresh_req) begin
            sample_inputs = 1'b1;
            state_d       = S_ADDR1;
          end
        end
        default: begin
          if ((state_q == S_INIT) && (idx_q >= InitCmds)) begin
            // Idle ticks after the clear command
            if (idx_q == InitLast) begin
              idx_d         = '0;
              sample_inputs = 1'b1;
              state_d       = S_ADDR1;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end else if (!phase_q) begin
            phase_d = 1'b1;
            e_d     = 1'b1;
            rs_d    = wr_rs;
            data_d  = wr_byte;
          end else begin
            phase_d = 1'b0;
            e_d     = 1'b0;
            idx_d   = idx_q + 4'd1;
            case (state_q)
              S_ADDR1: begin
                state_d = S_LINE1;
                idx_d   = '0;
              end
              S_LINE1: begin
                if (idx_q == CharLast) begin
                  state_d = S_ADDR2;
                  idx_d   = '0;
                end
              end
              S_ADDR2: begin
                state_d = S_LINE2;
                idx_d   = '0;
              end
              S_LINE2: begin
                if (idx_q == CharLast) begin
                  state_d = S_IDLE;
                  idx_d   = '0;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_POWERUP;
      cnt_q         <= '0;
      pwr_q         <= '0;
      idx_q         <= '0;
      phase_q       <= 1'b0;
      e_q           <= 1'b0;
      rs_q          <= 1'b0;
      data_q        <= 8'h00;
      shown_state_q <= 4'h0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pwr_q         <= pwr_d;
      idx_q         <= idx_d;
      phase_q       <= phase_d;
      e_q           <= e_d;
      rs_q          <= rs_d;
      data_q        <= data_d;
      shown_state_q <= shown_state_d;
    end
  end

  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_e    = e_q;
  assign lcd_data = data_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_lcd_status_writer.sv
// Scoreboard bench for lcd_status_writer with TICK_CYCLES=4, POWERUP_TICKS=2.
module tb_lcd_status_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] state_in;
  logic [7:0] value_in;
  logic       lcd_rs, lcd_rw, lcd_e, busy;
  logic [7:0] lcd_data;

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  lcd_status_writer #(
    .TICK_CYCLES   (4),
    .POWERUP_TICKS (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .state_in (state_in),
    .value_in (value_in),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .lcd_data (lcd_data),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] b);
    exp_q.push_back({rs, b});
  endtask

  task automatic push_init();
    push_byte(1'b0, 8'h38);
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h06);
    push_byte(1'b0, 8'h01);
  endtask

  task automatic push_refresh(input string line1, input logic [7:0] val);
    string hex;
    string pre;
    hex = "0123456789ABCDEF";
    pre = "VAL=0x";
    push_byte(1'b0, 8'h80);
    for (int i = 0; i < 16; i++) push_byte(1'b1, (i < line1.len()) ? line1[i] : 8'h20);
    push_byte(1'b0, 8'hC0);
    for (int i = 0; i < 16; i++) begin
`ifdef LCD_VALUE_FIELD_EN
      if (i < 6)       push_byte(1'b1, pre[i]);
      else if (i == 6) push_byte(1'b1, hex[val[7:4]]);
      else if (i == 7) push_byte(1'b1, hex[val[3:0]]);
      else             push_byte(1'b1, 8'h20);
`else
      push_byte(1'b1, (val === 8'hxx) ? pre[0] : 8'h20);
`endif
    end
  endtask

  task automatic wait_busy(input logic lvl, input int bound, input string name);
    int cyc;
    cyc = 0;
    while (busy !== lvl && cyc < bound) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (busy !== lvl) begin
      total++;
      bad++;
      $display("FAIL %s: busy=%0b after %0d clocks, required %0b", name, busy, cyc, lvl);
    end
  endtask

  task automatic first_write_latency(input string name);
    int cyc;
    cyc = 0;
    while (lcd_e !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check(name, cyc, 12);
  endtask

  // Monitor: pop and compare on each rising E, then check pulse width and data hold.
  initial begin
    logic       e_prev;
    int         hi_cnt;
    int         low_cnt;
    logic [7:0] cap;
    logic [8:0] exp_w;
    e_prev  = 1'b0;
    hi_cnt  = 0;
    low_cnt = -1;
    cap     = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst === 1'b1) begin
        e_prev  = 1'b0;
        hi_cnt  = 0;
        low_cnt = -1;
      end else begin
        if (lcd_e && !e_prev) begin
          hi_cnt  = 1;
          low_cnt = -1;
          cap     = lcd_data;
          check("lcd_rw at write", lcd_rw, 0);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected write: got rs=%0b data=0x%02h, required none",
                     lcd_rs, lcd_data);
          end else begin
            exp_w = exp_q.pop_front();
            check("write byte {rs,data}", {lcd_rs, lcd_data}, exp_w);
          end
        end else if (lcd_e) begin
          hi_cnt++;
        end else if (e_prev) begin
          check("e high clocks", hi_cnt, 4);
          check("data hold at e fall", lcd_data, cap);
          low_cnt = 1;
        end else if (low_cnt > 0) begin
          low_cnt++;
          if (low_cnt == 3) begin
            check("data hold in low phase", lcd_data, cap);
            low_cnt = -1;
          end
        end
        e_prev = lcd_e;
      end
    end
  end

  initial begin
    logic [7:0] val;
    int cyc;
    rst      = 1'b1;
    state_in = 4'd0;
    value_in = 8'h00;
    val      = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset lcd_e", lcd_e, 0);
    check("reset lcd_rs", lcd_rs, 0);
    check("reset lcd_data", lcd_data, 8'h00);
    check("reset busy", busy, 1);
    check("reset lcd_rw", lcd_rw, 0);

    // Power-up, init and "HOLA"
    push_init();
    push_refresh("HOLA", val);
    @(negedge clk);
    rst = 1'b0;
    first_write_latency("first write latency clocks");
    wait_busy(1'b0, 2000, "init refresh complete");
    check("queue drained after init", exp_q.size(), 0);

    // 0 -> 3 refresh and its exact length
    @(negedge clk);
    state_in = 4'd3;
    push_refresh("FALLA S2", val);
    wait_busy(1'b1, 8, "refresh start 0->3");
    cyc = 0;
    while (busy && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("refresh length clocks", cyc, 272);
    check("queue drained after 0->3", exp_q.size(), 0);

    // Changes in flight: 1 completes, then exactly one refresh for 12
    @(negedge clk);
    state_in = 4'd1;
    push_refresh("MIDIENDO", val);
    push_refresh("FALLA DEF S2", val);
    wait_busy(1'b1, 8, "refresh start 3->1");
    repeat (20) @(negedge clk);
    state_in = 4'd5;
    repeat (40) @(negedge clk);
    state_in = 4'd12;
    wait_busy(1'b0, 400, "refresh 1 complete");
    check("queue after first of pair", exp_q.size(), 34);
    wait_busy(1'b1, 8, "follow-up refresh start");
    wait_busy(1'b0, 400, "follow-up refresh complete");
    repeat (60) @(posedge clk);
    #1;
    check("idle after follow-up", busy, 0);
    check("queue drained after pair", exp_q.size(), 0);

    // Value change with state unchanged
    @(negedge clk);
    value_in = 8'hA7;
`ifdef LCD_VALUE_FIELD_EN
    val = 8'hA7;
    push_refresh("FALLA DEF S2", val);
    wait_busy(1'b1, 8, "value refresh start");
    wait_busy(1'b0, 400, "value refresh complete");
    check("queue drained after value", exp_q.size(), 0);
`else
    repeat (40) @(posedge clk);
    #1;
    check("no refresh on value change", busy, 0);
`endif

    // Extra message codes
    @(negedge clk);
    state_in = 4'd7;
    push_refresh("ABRIENDO S3", val);
    wait_busy(1'b1, 8, "refresh start 7");
    wait_busy(1'b0, 400, "refresh 7 complete");
    @(negedge clk);
    state_in = 4'd14;
    push_refresh("ESTADO ??", val);
    wait_busy(1'b1, 8, "refresh start 14");
    wait_busy(1'b0, 400, "refresh 14 complete");
    check("queue drained after 7/14", exp_q.size(), 0);

    // Reset during line 1 restarts everything
    @(negedge clk);
    state_in = 4'd8;
    push_refresh("CERRANDO S1", val);
    wait_busy(1'b1, 8, "refresh start 8");
    repeat (22) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid-refresh reset lcd_e", lcd_e, 0);
    check("mid-refresh reset busy", busy, 1);
    check("mid-refresh reset lcd_data", lcd_data, 8'h00);
    exp_q.delete();
    push_init();
    push_refresh("CERRANDO S1", val);
    @(negedge clk);
    rst = 1'b0;
    first_write_latency("write latency after reset");
    wait_busy(1'b0, 2000, "re-init refresh complete");
    repeat (20) @(posedge clk);
    #1;
    check("queue drained at end", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_status_writer.md
LCD_STATUS_WRITER -- requirements
Module: lcd_status_writer

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 50000, clk cycles per LCD timing tick (1 ms at 50 MHz).
REQ-002 SHALL have parameter POWERUP_TICKS, default 20, ticks waited after reset before the first command.
REQ-003 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port state_in  in  4  FSM state code from the main control FSM.
REQ-006 SHALL have port value_in  in  8  FSM output_signal byte.
REQ-007 SHALL have ports lcd_rs, lcd_rw, lcd_e  out  1 each  HD44780 control; lcd_rw is constant 0.
REQ-008 SHALL have port lcd_data  out  8  HD44780 8-bit data bus.
REQ-009 SHALL have port busy  out  1  high whenever the block is not in S_IDLE.

Function
REQ-010 SHALL generate a one-clk tick strobe every TICK_CYCLES clocks from a free-running counter; all sequencing advances only on tick.
REQ-011 SHALL use states S_POWERUP, S_INIT, S_IDLE, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2.
REQ-012 SHALL write each byte as 2 ticks: tick 1 drives lcd_rs/lcd_data and sets lcd_e=1; tick 2 holds lcd_rs/lcd_data and sets lcd_e=0.
REQ-013 S_POWERUP SHALL wait POWERUP_TICKS ticks, then enter S_INIT.
REQ-014 S_INIT SHALL send commands 0x38, 0x0C, 0x06, 0x01 (rs=0), followed by 2 extra idle ticks after 0x01, then enter S_ADDR1 with shown_state set to state_in.
REQ-015 S_ADDR1 SHALL send 0x80; S_LINE1 SHALL send 16 characters (rs=1) of the message for shown_state.
REQ-016 Message map: 0 "HOLA", 1 "MIDIENDO", 2-4 "FALLA Sn", 5-7 "ABRIENDO Sn", 8-10 "CERRANDO Sn", 11-13 "FALLA DEF Sn", 14-15 "ESTADO ??"; Sn = S1/S2/S3 in code order; all messages space-padded to 16 characters.
REQ-017 S_ADDR2 SHALL send 0xC0; S_LINE2 SHALL send 16 characters per REQ-029/REQ-030, then enter S_IDLE.
REQ-018 S_IDLE SHALL, on a tick where state_in != shown_state or (macro on) value_in != shown_value, latch both inputs and enter S_ADDR1.
REQ-019 Inputs SHALL be sampled only at refresh start; changes during a refresh SHALL NOT alter the message in flight and SHALL be picked up in S_IDLE after completion.
REQ-020 A full refresh SHALL take exactly 68 ticks (34 bytes x 2).
REQ-021 In S_IDLE, lcd_e SHALL be 0 and lcd_data SHALL hold its last value.

Reset
REQ-022 On rst: state=S_POWERUP, tick counter=0, lcd_e=0, lcd_rs=0, lcd_data=0x00, busy=1, shown_state=0, shown_value=0.
REQ-023 rst asserted mid-refresh SHALL abort the refresh and restart the full power-up and init sequence.

Configuration
REQ-024 Macro LCD_VALUE_FIELD_EN SHALL control value display on line 2.
REQ-025 With LCD_VALUE_FIELD_EN defined, line 2 SHALL be "VAL=0x" + two uppercase hex digits of shown_value + 8 spaces, and value changes SHALL trigger a refresh.
REQ-026 Without LCD_VALUE_FIELD_EN, line 2 SHALL be 16 spaces, value_in SHALL be ignored, and shown_value register SHALL not exist.

Structure
REQ-027 SHALL place state codes 0-13 (matching the main FSM), LCD command constants, and message length 16 in package lcd_status_pkg.
REQ-028 SHALL use sub-module lcd_msg_rom (combinational: state code + char index 0-15 -> ASCII byte).
REQ-029 Hex-to-ASCII conversion SHALL be local: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
REQ-030 The tick counter SHALL be sized to $clog2(TICK_CYCLES).

Verification (TICK_CYCLES=4, POWERUP_TICKS=2)
REQ-031 Reset with state_in=0 -> lcd_e low for 2 ticks, then 0x38,0x0C,0x06,0x01 with rs=0, then 0x80 and "HOLA" + 12 spaces with rs=1; busy falls after the last byte.
REQ-032 In S_IDLE, state_in 0->3 -> refresh starts at the next tick, line 1 "FALLA S2", 68 ticks later busy=0.
REQ-033 state_in changes 1->5->12 mid-refresh -> the current message completes unchanged, then exactly one refresh shows "FALLA DEF S2".
REQ-034 Macro on, value_in=0xA7 with state unchanged -> refresh, line 2 bytes 0x56 0x41 0x4C 0x3D 0x30 0x78 0x41 0x37; macro off -> no refresh occurs.
REQ-035 rst pulsed during S_LINE1 -> next cycle lcd_e=0, busy=1, and the full init sequence repeats.
REQ-036 Every write -> lcd_e high for exactly TICK_CYCLES clocks, and lcd_data stable across both phases.
